// File: rtl/nv_ram_rwsp_param_if.sv
// Port bundle for nv_ram_rwsp_param: one read port, one masked write port, status flags.
// The RAM sits on the slave modport. The traffic source sits on the master modport.
interface nv_ram_rwsp_param_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 8
);
    logic [AW-1:0]    ra;
    logic             re;
    logic             ore;
    logic [WIDTH-1:0] dout;
    logic [AW-1:0]    wa;
    logic             we;
    logic [WIDTH-1:0] di;
    logic [WIDTH-1:0] wmsk;
    logic [31:0]      pwrbus_ram_pd;
    logic             init_done;
    logic             rd_oor;
    logic             wr_oor;
    // FSM state for observation: 0 = clear sweep, 1 = run
    logic             dbg_state;

    // re/we/ore act on the rising edge at which they are high. The port has no back-pressure.
    // init_done=1 means the array accepts traffic. Before that, the RAM ignores we, re and ore.
    modport master (
        output ra, re, ore, wa, we, di, wmsk, pwrbus_ram_pd,
        input  dout, init_done, rd_oor, wr_oor, dbg_state
    );

    modport slave (
        input  ra, re, ore, wa, we, di, wmsk, pwrbus_ram_pd,
        output dout, init_done, rd_oor, wr_oor, dbg_state
    );
endinterface

// File: rtl/nv_ram_rwsp_param.sv
// Parametrised 1R1W RAM with registered read address, optional output register,
// per-bit write mask, post-reset clear sweep and sticky out-of-range flags.
module nv_ram_rwsp_param #(
    parameter int DEPTH    = 160,
    parameter int WIDTH    = 16,
    parameter int AW       = 8,
    parameter int OUT_REG  = 1,
    parameter int INIT_CLR = 1
) (
    input  logic                clk,
    input  logic                rstn,
    nv_ram_rwsp_param_if.slave  bus
);
    typedef enum logic {ST_CLR = 1'b0, ST_RUN = 1'b1} state_t;

    // DEPTH may equal 2**AW, so range checks use one extra bit
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam state_t        ST_RST    = (INIT_CLR != 0) ? ST_CLR : ST_RUN;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_clr_addr;
    logic [AW-1:0]    r_ra_d;
    logic [WIDTH-1:0] r_dout;
    logic             r_init_done;
    logic             r_rd_oor;
    logic             r_wr_oor;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_wa_ok;
    logic             w_ra_ok;
    logic             w_rad_ok;
    logic [WIDTH-1:0] w_rd_word;
    logic             w_mem_we;
    logic [AW-1:0]    w_mem_addr;
    logic [WIDTH-1:0] w_mem_di;
    logic [WIDTH-1:0] w_mem_msk;
    logic             w_rd_cap;
    logic             w_out_en;
    logic             w_clr_last;
    logic             w_run;

    assign w_wa_ok  = ({1'b0, bus.wa} < DEPTH_W);
    assign w_ra_ok  = ({1'b0, bus.ra} < DEPTH_W);
    assign w_rad_ok = ({1'b0, r_ra_d} < DEPTH_W);
    assign w_run    = (r_state == ST_RUN);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_we    = 1'b0;
        w_mem_addr  = bus.wa;
        w_mem_di    = bus.di;
        w_mem_msk   = bus.wmsk;
        w_rd_cap    = 1'b0;
        w_out_en    = 1'b0;
        w_clr_last  = 1'b0;
        case (r_state)
            ST_CLR: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_clr_addr;
                w_mem_di   = '0;
                w_mem_msk  = '1;
                if (r_clr_addr == LAST_ADDR) begin
                    w_clr_last  = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_mem_we = bus.we && w_wa_ok;
                w_rd_cap = bus.re;
                w_out_en = bus.ore;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // The array has no reset. The write port is idle while rstn is low.
    always_ff @(posedge clk) begin
        if (rstn && w_mem_we) begin
            r_mem[w_mem_addr] <= (r_mem[w_mem_addr] & ~w_mem_msk) | (w_mem_di & w_mem_msk);
        end
    end

    // Read data sees every write from earlier edges. This makes a same-edge we/re collision write-first.
    assign w_rd_word = w_rad_ok ? r_mem[r_ra_d] : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_clr_addr  <= '0;
            r_ra_d      <= '0;
            r_dout      <= '0;
            r_init_done <= 1'b0;
            r_rd_oor    <= 1'b0;
            r_wr_oor    <= 1'b0;
        end else begin
            r_init_done <= r_init_done | w_clr_last | w_run;
            if (!w_run) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
            if (w_rd_cap) begin
                r_ra_d <= bus.ra;
                if (!w_ra_ok) begin
                    r_rd_oor <= 1'b1;
                end
            end
            if (w_run && bus.we && !w_wa_ok) begin
                r_wr_oor <= 1'b1;
            end
            if (w_out_en) begin
                r_dout <= w_rd_word;
            end
        end
    end

    assign bus.dout      = (OUT_REG != 0) ? r_dout : w_rd_word;
    assign bus.init_done = r_init_done;
    assign bus.rd_oor    = r_rd_oor;
    assign bus.wr_oor    = r_wr_oor;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_nv_ram_rwsp_param.sv
// Bench for nv_ram_rwsp_param: registered/clearing build (u_dut0) and
// combinational/no-clear build (u_dut1), checked against a word model and an expected queue.
module tb_nv_ram_rwsp_param;
    logic clk = 1'b0;
    logic rstn0;
    logic rstn1;
    int   n_vec = 0;
    int   n_err = 0;

    logic [15:0] exp_q[$];
    logic [15:0] mdl [160];

    always #5 clk = ~clk;

    nv_ram_rwsp_param_if #(.WIDTH(16), .AW(8)) b0 ();
    nv_ram_rwsp_param_if #(.WIDTH(16), .AW(8)) b1 ();

    nv_ram_rwsp_param #(
        .DEPTH(160), .WIDTH(16), .AW(8), .OUT_REG(1), .INIT_CLR(1)
    ) u_dut0 (
        .clk  (clk),
        .rstn (rstn0),
        .bus  (b0)
    );

    nv_ram_rwsp_param #(
        .DEPTH(160), .WIDTH(16), .AW(8), .OUT_REG(0), .INIT_CLR(0)
    ) u_dut1 (
        .clk  (clk),
        .rstn (rstn1),
        .bus  (b1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_q_empty"}, exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, obs, e);
        end
    endtask

    // Inputs change 1 time unit after each rising edge. Outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
        b0.pwrbus_ram_pd = $urandom;
        b1.pwrbus_ram_pd = $urandom;
    endtask

    task automatic idle0();
        b0.we = 1'b0; b0.re = 1'b0; b0.ore = 1'b0;
        b0.wa = '0; b0.ra = '0; b0.di = '0; b0.wmsk = '0;
    endtask

    task automatic wr0(input logic [7:0] a, input logic [15:0] d, input logic [15:0] m);
        b0.we = 1'b1; b0.wa = a; b0.di = d; b0.wmsk = m;
        tick();
        b0.we = 1'b0;
        if (a < 8'd160) mdl[a] = (mdl[a] & ~m) | (d & m);
    endtask

    task automatic rd0(input logic [7:0] a, input string tag);
        exp_q.push_back((a < 8'd160) ? mdl[a] : 16'h0000);
        b0.re = 1'b1; b0.ra = a;
        tick();
        b0.re = 1'b0; b0.ore = 1'b1;
        tick();
        b0.ore = 1'b0;
        sb_check(tag, b0.dout);
    endtask

    // Traffic is driven at random while the sweep runs. The RAM ignores it, and dout must stay 0.
    task automatic sweep0(input string tag);
        int n  = 0;
        int nz = 0;
        while (b0.init_done !== 1'b1 && n < 400) begin
            b0.we = 1'($urandom_range(0, 1)); b0.wa = 8'($urandom_range(0, 255));
            b0.re = 1'($urandom_range(0, 1)); b0.ra = 8'($urandom_range(0, 255));
            b0.ore = 1'($urandom_range(0, 1));
            b0.di = 16'hFFFF; b0.wmsk = 16'hFFFF;
            tick();
            n++;
            if (b0.dout !== 16'h0000) nz++;
        end
        idle0();
        check_eq({tag, "_len"}, n, 160);
        check_eq({tag, "_dout0"}, nz, 0);
        for (int i = 0; i < 160; i++) mdl[i] = 16'h0000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz;
        rstn0 = 1'b0;
        rstn1 = 1'b0;
        idle0();
        b1.we = 1'b0; b1.re = 1'b0; b1.ore = 1'b0;
        b1.wa = '0; b1.ra = '0; b1.di = '0; b1.wmsk = '0;
        b0.pwrbus_ram_pd = '0; b1.pwrbus_ram_pd = '0;
        repeat (3) tick();

        check_eq("rst_init_done", b0.init_done, 0);
        check_eq("rst_dout", b0.dout, 0);
        check_eq("rst_rd_oor", b0.rd_oor, 0);
        check_eq("rst_wr_oor", b0.wr_oor, 0);
        check_eq("rst_state", b0.dbg_state, 0);

        rstn0 = 1'b1;
        sweep0("sweep");
        check_eq("sweep_rd_oor", b0.rd_oor, 0);
        check_eq("sweep_wr_oor", b0.wr_oor, 0);
        check_eq("run_state", b0.dbg_state, 1);
        rd0(8'd0, "clr_0");
        rd0(8'd80, "clr_80");
        rd0(8'd159, "clr_159");

        wr0(8'd5, 16'hABCD, 16'hFFFF);
        wr0(8'd5, 16'h1234, 16'h00FF);
        exp_q.push_back(16'hAB34);
        b0.re = 1'b1; b0.ra = 8'd5;
        tick();
        b0.re = 1'b0; b0.ore = 1'b1;
        tick();
        b0.ore = 1'b0;
        sb_check("mask_5", b0.dout);
        b0.re = 1'b1; b0.ra = 8'd80;
        tick();
        b0.re = 1'b0; b0.ra = 8'd3;
        tick();
        tick();
        check_eq("hold_ore0", b0.dout, 16'hAB34);

        wr0(8'd7, 16'h1111, 16'hFFFF);
        exp_q.push_back(16'h2222);
        b0.we = 1'b1; b0.wa = 8'd7; b0.di = 16'h2222; b0.wmsk = 16'hFFFF;
        b0.re = 1'b1; b0.ra = 8'd7;
        tick();
        mdl[7] = 16'h2222;
        b0.we = 1'b0; b0.re = 1'b0; b0.ore = 1'b1;
        tick();
        b0.ore = 1'b0;
        sb_check("collide_7", b0.dout);

        exp_q.push_back(16'hBEEF);
        b0.re = 1'b1; b0.ra = 8'd9;
        tick();
        b0.re = 1'b0;
        wr0(8'd9, 16'hBEEF, 16'hFFFF);
        b0.ore = 1'b1;
        tick();
        b0.ore = 1'b0;
        sb_check("wr_between", b0.dout);

        wr0(8'd5, 16'hFFFF, 16'h0000);
        rd0(8'd5, "mask0_5");

        wr0(8'd40, 16'h5A5A, 16'hFFFF);
        check_eq("wr_oor_pre", b0.wr_oor, 0);
        wr0(8'd200, 16'hFFFF, 16'hFFFF);
        check_eq("wr_oor_set", b0.wr_oor, 1);
        check_eq("rd_oor_clr", b0.rd_oor, 0);
        rd0(8'd40, "no_alias_40");
        rd0(8'd200, "oor_200");
        rd0(8'd170, "oor_170");
        check_eq("rd_oor_set", b0.rd_oor, 1);
        rd0(8'd160, "oor_160");
        wr0(8'd255, 16'h0F0F, 16'hFFFF);
        rd0(8'd159, "edge_159");

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                wr0(8'($urandom_range(0, 175)), 16'($urandom), 16'($urandom));
            else
                rd0(8'($urandom_range(0, 175)), "rand_rd");
        end

        repeat (5) tick();
        check_eq("sticky_rd", b0.rd_oor, 1);
        check_eq("sticky_wr", b0.wr_oor, 1);

        rstn0 = 1'b0;
        tick();
        check_eq("rst2_init_done", b0.init_done, 0);
        check_eq("rst2_rd_oor", b0.rd_oor, 0);
        check_eq("rst2_wr_oor", b0.wr_oor, 0);
        rstn0 = 1'b1;
        nz = 0;
        repeat (50) begin
            tick();
            if (b0.dout !== 16'h0000) nz++;
        end
        rstn0 = 1'b0;
        tick();
        check_eq("mid_init_done", b0.init_done, 0);
        check_eq("mid_state", b0.dbg_state, 0);
        check_eq("mid_dout0", nz, 0);
        rstn0 = 1'b1;
        sweep0("resweep");
        rd0(8'd5, "reclr_5");
        rd0(8'd40, "reclr_40");
        rd0(8'd159, "reclr_159");

        check_eq("d1_rst_init_done", b1.init_done, 0);
        rstn1 = 1'b1;
        tick();
        check_eq("d1_init_done", b1.init_done, 1);
        check_eq("d1_state", b1.dbg_state, 1);
        b1.we = 1'b1; b1.wa = 8'd3; b1.di = 16'h00F0; b1.wmsk = 16'hFFFF;
        tick();
        b1.we = 1'b0;
        exp_q.push_back(16'h00F0);
        b1.re = 1'b1; b1.ra = 8'd3; b1.ore = 1'b0;
        tick();
        b1.re = 1'b0;
        sb_check("d1_comb_3", b1.dout);
        b1.ore = 1'b1; b1.ra = 8'd50;
        tick();
        b1.ore = 1'b0;
        check_eq("d1_ore_ign", b1.dout, 16'h00F0);
        exp_q.push_back(16'h0000);
        b1.re = 1'b1; b1.ra = 8'd200;
        tick();
        b1.re = 1'b0;
        sb_check("d1_oor_200", b1.dout);
        check_eq("d1_rd_oor", b1.rd_oor, 1);
        check_eq("d1_wr_oor", b1.wr_oor, 0);

        check_eq("q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
